tx_frame_scheduler: RTL and testbench



---
 rtl/aurora_pkg.sv | 28 ++
 rtl/cc_timer.sv | 38 +++
 rtl/tx_frame_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared types and constants for the lane transmit path.
// Symbol classes, scheduler states and default timing.
package aurora_pkg;

    localparam int MAX_LINKS         = 4;
    localparam int MAX_LINKS_SIZE    = 2;
    localparam int AXI_DATA_SIZE     = 32;
    localparam int CC_PERIOD_DEFAULT = 2500;
    localparam int CC_LEN_DEFAULT    = 3;

    typedef enum logic [2:0] {
        SYM_IDLE,
        SYM_SCP,
        SYM_ECP,
        SYM_CC,
        SYM_DATA
    } tx_sym_e;

    typedef enum logic [2:0] {
        S_DOWN,
        S_IDLE,
        S_SOF,
        S_DATA,
        S_EOF,
        S_CC
    } tx_sched_state_e;

endpackage

// File: rtl/cc_timer.sv
// Clock-compensation period counter with a sticky request flag.
// Held cleared while disabled so the period restarts on link-up.
module cc_timer
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = CC_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear_req,
    output logic cc_due
);

    localparam int CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(CC_PERIOD - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == LAST);

    // A wrap wins over a clear; repeated wraps collapse into one request.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt    <= '0;
            cc_due <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) begin
                cc_due <= 1'b1;
            end else if (clear_req) begin
                cc_due <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Per-lane transmit sequencer: IDLE / SCP / DATA / ECP / CC.
// Registered symbol outputs; axi_ready is combinational.
module tx_frame_scheduler
    import aurora_pkg::*;
#(
    parameter int MAX_LINKS      = aurora_pkg::MAX_LINKS,
    parameter int MAX_LINKS_SIZE = aurora_pkg::MAX_LINKS_SIZE,
    parameter int AXI_DATA_SIZE  = aurora_pkg::AXI_DATA_SIZE,
    parameter int CC_PERIOD      = CC_PERIOD_DEFAULT,
    parameter int CC_LEN         = CC_LEN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      single_lane,
    input  logic [MAX_LINKS_SIZE-1:0] lane_select,
    input  logic                      channel_init_finished,
    input  logic                      axi_valid,
    input  logic                      axi_last,
    input  logic [AXI_DATA_SIZE-1:0]  axi_data,
    output logic                      axi_ready,
    output tx_sym_e                   tx_sym,
    output logic [AXI_DATA_SIZE-1:0]  tx_data,
    output logic [MAX_LINKS-1:0]      tx_lane_en,
    output logic                      frame_abort
);

    localparam int LW = $clog2(CC_LEN + 1);

    tx_sched_state_e state, state_nxt;
    tx_sched_state_e ret_state, ret_nxt;
    logic [LW-1:0]   cc_cnt, cnt_nxt;

    logic                 cc_due;
    logic                 clear_req;
    logic                 chan;
    logic                 beat;
    logic                 abort_nxt;
    tx_sym_e              sym_nxt;
    logic [MAX_LINKS-1:0] lane_mask;

    assign chan = channel_init_finished;

    cc_timer #(
        .CC_PERIOD(CC_PERIOD)
    ) u_cc_timer (
        .clk      (clk),
        .rst      (rst),
        .enable   (state != S_DOWN),
        .clear_req(clear_req),
        .cc_due   (cc_due)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DOWN;
            ret_state <= S_IDLE;
            cc_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            cc_cnt    <= cnt_nxt;
        end
    end

    // A preempting burst emits its first CC in the deciding cycle,
    // so S_CC then covers the remaining CC_LEN-1 cycles.
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        cnt_nxt   = cc_cnt;
        if (state != S_DOWN && !chan) begin
            state_nxt = S_DOWN;
        end else begin
            unique case (state)
                S_DOWN: begin
                    if (chan) state_nxt = S_IDLE;
                end
                S_IDLE, S_DATA: begin
                    if (cc_due) begin
                        ret_nxt = state;
                        cnt_nxt = LW'(1);
                        if (CC_LEN > 1) state_nxt = S_CC;
                    end else if (state == S_IDLE) begin
                        if (axi_valid) state_nxt = S_SOF;
                    end else if (beat && axi_last) begin
                        state_nxt = S_EOF;
                    end
                end
                S_SOF: state_nxt = S_DATA;
                S_EOF: begin
                    if (cc_due) begin
                        state_nxt = S_CC;
                        ret_nxt   = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_CC: begin
                    if (cc_cnt >= LW'(CC_LEN - 1)) begin
                        state_nxt = ret_state;
                    end else begin
                        cnt_nxt = cc_cnt + LW'(1);
                    end
                end
                default: state_nxt = S_DOWN;
            endcase
        end
    end

    always_comb begin
        axi_ready = (state == S_DATA) && !cc_due && chan;
        beat      = axi_valid && axi_ready;
        abort_nxt = !chan && ((state == S_SOF) || (state == S_DATA) ||
                    ((state == S_CC) && (ret_state == S_DATA)));
        sym_nxt   = SYM_IDLE;
        if (chan) begin
            unique case (state)
                S_IDLE:  sym_nxt = cc_due ? SYM_CC : SYM_IDLE;
                S_SOF:   sym_nxt = SYM_SCP;
                S_DATA: begin
                    if (cc_due)    sym_nxt = SYM_CC;
                    else if (beat) sym_nxt = SYM_DATA;
                    else           sym_nxt = SYM_IDLE;
                end
                S_EOF:   sym_nxt = SYM_ECP;
                S_CC:    sym_nxt = SYM_CC;
                default: sym_nxt = SYM_IDLE;
            endcase
        end
        clear_req = (sym_nxt == SYM_CC);
    end

    // Out-of-range selects fall back to lane 0.
    always_comb begin
        lane_mask = '0;
        if (!single_lane) begin
            lane_mask = '1;
        end else begin
            for (int i = 0; i < MAX_LINKS; i++) begin
                if (lane_select == MAX_LINKS_SIZE'(i)) lane_mask[i] = 1'b1;
            end
            if (lane_mask == '0) lane_mask[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sym      <= SYM_IDLE;
            tx_data     <= '0;
            tx_lane_en  <= '0;
            frame_abort <= 1'b0;
        end else begin
            tx_sym      <= sym_nxt;
            frame_abort <= abort_nxt;
            if (beat) tx_data <= axi_data;
            if (state == S_IDLE) tx_lane_en <= lane_mask;
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scenario bench for tx_frame_scheduler with a data scoreboard.
// Runs with a short CC period so bursts land inside frames.
module tb_tx_frame_scheduler;
    import aurora_pkg::*;

    localparam int P = 16;
    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        single_lane = 1'b0;
    logic [1:0]  lane_select = '0;
    logic        chan = 1'b0;
    logic        axi_valid = 1'b0;
    logic        axi_last = 1'b0;
    logic [31:0] axi_data = '0;
    logic        axi_ready;
    tx_sym_e     tx_sym;
    logic [31:0] tx_data;
    logic [3:0]  tx_lane_en;
    logic        frame_abort;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .MAX_LINKS     (4),
        .MAX_LINKS_SIZE(2),
        .AXI_DATA_SIZE (32),
        .CC_PERIOD     (P),
        .CC_LEN        (L)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .single_lane          (single_lane),
        .lane_select          (lane_select),
        .channel_init_finished(chan),
        .axi_valid            (axi_valid),
        .axi_last             (axi_last),
        .axi_data             (axi_data),
        .axi_ready            (axi_ready),
        .tx_sym               (tx_sym),
        .tx_data              (tx_data),
        .tx_lane_en           (tx_lane_en),
        .frame_abort          (frame_abort)
    );

    // Scoreboard: accepted beats are queued, DATA symbols pop them.
    always @(negedge clk) begin
        logic [31:0] e;
        if (tx_sym == SYM_DATA) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_data: got %h, want none (queue empty)",
                         tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h want %h", tx_data, e);
                end
            end
        end
        if (rst) exp_q.delete();
        else if (axi_valid && axi_ready) exp_q.push_back(axi_data);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input int n,
                         input logic [31:0] base, input logic en);
        axi_valid = en && (idx < n);
        axi_data  = base + 32'(idx);
        axi_last  = (idx == n - 1);
    endtask

    // Leaves the bench in cycle 0: init seen at the next edge.
    task automatic bring_up(input logic single, input logic [1:0] sel);
        go();
        rst = 1'b1;
        chan = 1'b0;
        axi_valid = 1'b0;
        axi_last = 1'b0;
        single_lane = single;
        lane_select = sel;
        go();
        go();
        rst = 1'b0;
        chan = 1'b1;
    endtask

    task automatic check_q_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left: got %0d want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        go();
        rst = 1'b1;
        chan = 1'b0;
        axi_valid = 1'b0;
        go();
        go();
        @(negedge clk);
        checks++;
        if (tx_sym !== SYM_IDLE || tx_data !== 32'h0 ||
            tx_lane_en !== 4'h0 || frame_abort !== 1'b0 ||
            axi_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: got %s %h %b %b %b want IDLE 0 0 0 0",
                     tx_sym.name(), tx_data, tx_lane_en, frame_abort,
                     axi_ready);
        end
        go();
        rst = 1'b0;
        go();
        @(negedge clk);
        checks++;
        if (tx_sym !== SYM_IDLE || axi_ready !== 1'b0) begin
            errors++;
            $display("FAIL down_hold: got %s %b want IDLE 0",
                     tx_sym.name(), axi_ready);
        end
    endtask

    task automatic test_single_frame();
        tx_sym_e exp_s[8] = '{SYM_IDLE, SYM_IDLE, SYM_SCP, SYM_DATA,
                              SYM_DATA, SYM_DATA, SYM_ECP, SYM_IDLE};
        bit      exp_r[8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        int idx = 0;
        int rdy = 0;
        bring_up(1'b0, 2'd0);
        for (int k = 0; k < 8; k++) begin
            go();
            drive(idx, 3, 32'hA1, 1'b1);
            @(negedge clk);
            checks++;
            if (tx_sym !== exp_s[k]) begin
                errors++;
                $display("FAIL single_sym[%0d]: got %s want %s", k + 1,
                         tx_sym.name(), exp_s[k].name());
            end
            checks++;
            if (axi_ready !== exp_r[k]) begin
                errors++;
                $display("FAIL single_rdy[%0d]: got %b want %b", k + 1,
                         axi_ready, exp_r[k]);
            end
            if (axi_ready) rdy++;
            if (axi_valid && axi_ready) idx++;
        end
        checks++;
        if (rdy != 3) begin
            errors++;
            $display("FAIL single_rdy_cnt: got %0d want 3", rdy);
        end
        check_q_empty("single");
    endtask

    task automatic test_cc_preempt();
        int idx = 0;
        int stall = 0;
        int ndata = 0;
        int ncc = 0;
        int starts[$];
        tx_sym_e prev = SYM_IDLE;
        bring_up(1'b0, 2'd0);
        for (int k = 1; k <= 40; k++) begin
            go();
            drive(idx, 20, 32'h1000, 1'b1);
            @(negedge clk);
            if (tx_sym == SYM_CC && prev != SYM_CC) starts.push_back(k);
            if (tx_sym == SYM_CC) ncc++;
            if (tx_sym == SYM_DATA) ndata++;
            if (k >= 3 && axi_valid && !axi_ready) stall++;
            prev = tx_sym;
            if (axi_valid && axi_ready) idx++;
        end
        checks++;
        if (starts.size() != 2) begin
            errors++;
            $display("FAIL cc_bursts: got %0d want 2", starts.size());
        end else begin
            checks++;
            if (starts[0] != 18) begin
                errors++;
                $display("FAIL cc_first: got cycle %0d want 18", starts[0]);
            end
            checks++;
            if (starts[1] - starts[0] != P) begin
                errors++;
                $display("FAIL cc_spacing: got %0d want %0d",
                         starts[1] - starts[0], P);
            end
        end
        checks++;
        if (stall != L) begin
            errors++;
            $display("FAIL cc_stall: got %0d want %0d", stall, L);
        end
        checks++;
        if (ncc != 2 * L) begin
            errors++;
            $display("FAIL cc_syms: got %0d want %0d", ncc, 2 * L);
        end
        checks++;
        if (ndata != 20) begin
            errors++;
            $display("FAIL cc_beats: got %0d want 20", ndata);
        end
        check_q_empty("cc");
    endtask

    task automatic test_gap();
        tx_sym_e exp_s[11] = '{SYM_IDLE, SYM_IDLE, SYM_SCP, SYM_DATA,
                               SYM_DATA, SYM_IDLE, SYM_IDLE, SYM_DATA,
                               SYM_DATA, SYM_ECP, SYM_IDLE};
        int idx = 0;
        bring_up(1'b0, 2'd0);
        for (int k = 1; k <= 11; k++) begin
            go();
            drive(idx, 4, 32'hB0, !(k == 5 || k == 6));
            @(negedge clk);
            checks++;
            if (tx_sym !== exp_s[k-1]) begin
                errors++;
                $display("FAIL gap_sym[%0d]: got %s want %s", k,
                         tx_sym.name(), exp_s[k-1].name());
            end
            if (axi_valid && axi_ready) idx++;
        end
        check_q_empty("gap");
    endtask

    task automatic test_lanes();
        logic [3:0] exp_l[9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0010,
                                 4'b1111};
        int idx = 0;
        bring_up(1'b1, 2'd2);
        for (int k = 1; k <= 9; k++) begin
            go();
            if (k == 3) lane_select = 2'd1;
            if (k == 8) single_lane = 1'b0;
            drive(idx, 2, 32'hC0, k >= 2);
            @(negedge clk);
            checks++;
            if (tx_lane_en !== exp_l[k-1]) begin
                errors++;
                $display("FAIL lane_en[%0d]: got %b want %b", k,
                         tx_lane_en, exp_l[k-1]);
            end
            if (k == 7) begin
                checks++;
                if (tx_sym !== SYM_ECP) begin
                    errors++;
                    $display("FAIL lane_ecp: got %s want SYM_ECP",
                             tx_sym.name());
                end
            end
            if (axi_valid && axi_ready) idx++;
        end
        check_q_empty("lanes");
    endtask

    task automatic test_chan_loss();
        tx_sym_e exp_s[16] = '{SYM_IDLE, SYM_IDLE, SYM_SCP, SYM_DATA,
                               SYM_DATA, SYM_DATA, SYM_IDLE, SYM_IDLE,
                               SYM_IDLE, SYM_IDLE, SYM_IDLE, SYM_SCP,
                               SYM_DATA, SYM_DATA, SYM_ECP, SYM_IDLE};
        bit exp_r[16] = '{0, 0, 1, 1, 1, 0, 0, 0,
                          0, 0, 0, 1, 1, 0, 0, 0};
        int idx = 0;
        int n = 10;
        int pulses = 0;
        logic [31:0] base = 32'hD0;
        bring_up(1'b0, 2'd0);
        for (int k = 1; k <= 16; k++) begin
            go();
            if (k == 6) chan = 1'b0;
            if (k == 9) begin
                chan = 1'b1;
                idx = 0;
                n = 2;
                base = 32'hE0;
            end
            drive(idx, n, base, (k <= 6) || (k >= 9));
            @(negedge clk);
            checks++;
            if (tx_sym !== exp_s[k-1]) begin
                errors++;
                $display("FAIL loss_sym[%0d]: got %s want %s", k,
                         tx_sym.name(), exp_s[k-1].name());
            end
            checks++;
            if (axi_ready !== exp_r[k-1]) begin
                errors++;
                $display("FAIL loss_rdy[%0d]: got %b want %b", k,
                         axi_ready, exp_r[k-1]);
            end
            checks++;
            if (frame_abort !== (k == 7)) begin
                errors++;
                $display("FAIL loss_abort[%0d]: got %b want %b", k,
                         frame_abort, (k == 7));
            end
            if (frame_abort) pulses++;
            if (axi_valid && axi_ready) idx++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL loss_pulses: got %0d want 1", pulses);
        end
        check_q_empty("loss");
    endtask

    task automatic test_reset_midframe();
        int idx = 0;
        int first_cc = 0;
        int aborts = 0;
        bring_up(1'b0, 2'd0);
        for (int k = 1; k <= 30; k++) begin
            go();
            if (k == 5) rst = 1'b1;
            if (k == 6) rst = 1'b0;
            drive(idx, 30, 32'hF0, k < 5);
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (tx_sym !== SYM_IDLE || tx_data !== 32'h0 ||
                    tx_lane_en !== 4'h0 || axi_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid: got %s %h %b %b want IDLE 0 0 0",
                             tx_sym.name(), tx_data, tx_lane_en, axi_ready);
                end
            end
            if (k >= 5 && frame_abort) aborts++;
            if (tx_sym == SYM_CC && first_cc == 0) first_cc = k;
            if (axi_valid && axi_ready) idx++;
        end
        checks++;
        if (aborts != 0) begin
            errors++;
            $display("FAIL rst_abort: got %0d want 0", aborts);
        end
        checks++;
        if (first_cc != 24) begin
            errors++;
            $display("FAIL rst_cc_first: got cycle %0d want 24", first_cc);
        end
        check_q_empty("rst");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_cc_preempt();
        test_gap();
        test_lanes();
        test_chan_loss();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
